// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Sits between the MEM stage and DataMemory; read hits finish without stalling,
// while misses and all stores wait for DataMemory's ready handshake.
module dcache_controller #(
    parameter int unsigned INDEX_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_write_data,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
    localparam int unsigned LINES    = 1 << INDEX_BITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_n;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [31:0]           data_q [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   ctag;
    logic                  hit;

    // Per-cycle actions decided by the control logic
    logic                  issue_wr;
    logic                  issue_rd;
    logic                  wr_hit;
    logic                  fill;
    logic                  clr_wr;
    logic                  hit_inc;
    logic                  miss_inc;

    assign idx  = cpu_address[INDEX_BITS+1:2];
    assign ctag = cpu_address[31:INDEX_BITS+2];
    assign hit  = valid_q[idx] && (tag_q[idx] == ctag);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, stall and read-data logic; a store takes priority over a load
    always_comb begin
        state_n       = state;
        cpu_stall     = 1'b0;
        cpu_read_data = data_q[idx];
        issue_wr      = 1'b0;
        issue_rd      = 1'b0;
        wr_hit        = 1'b0;
        fill          = 1'b0;
        clr_wr        = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_write) begin
                    cpu_stall = 1'b1;
                    issue_wr  = 1'b1;
                    wr_hit    = hit;
                    state_n   = ISSUE;
                end else if (cpu_read) begin
                    if (hit) begin
                        hit_inc = 1'b1;
                    end else begin
                        cpu_stall = 1'b1;
                        issue_rd  = 1'b1;
                        miss_inc  = 1'b1;
                        state_n   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Ready is ignored here so a stale ready cannot end the access early
                cpu_stall = 1'b1;
                state_n   = WAIT;
            end
            WAIT: begin
                cpu_stall = 1'b1;
                if (mem_ready) begin
                    fill    = !mem_write;
                    clr_wr  = mem_write;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Memory-side registers, counters and line valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_write      <= 1'b0;
            mem_address    <= 32'd0;
            mem_write_data <= 32'd0;
            hit_count      <= 32'd0;
            miss_count     <= 32'd0;
            valid_q        <= '0;
        end else begin
            if (issue_wr) begin
                mem_write      <= 1'b1;
                mem_address    <= cpu_address;
                mem_write_data <= cpu_write_data;
            end
            if (issue_rd) begin
                mem_write   <= 1'b0;
                mem_address <= cpu_address;
            end
            if (clr_wr) begin
                mem_write <= 1'b0;
            end
            if (hit_inc) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_inc) begin
                miss_count <= miss_count + 32'd1;
            end
            if (fill) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: refill on a completed read miss, update on a store hit
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx]  <= ctag;
            data_q[idx] <= mem_read_data;
        end else if (wr_hit) begin
            data_q[idx] <= cpu_write_data;
        end
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller with one-word lines.
- Sits between the MEM stage of the MIPS pipeline and DataMemory. It consumes DataMemory's mem_ready/read_data handshake and drives its mem_write/address/write_data inputs.
- Read hits complete with no stall. Misses and all writes stall the pipeline until DataMemory reports ready.

Parameters:
- INDEX_BITS, 5, log2 of line count (32 lines); index = cpu_address[INDEX_BITS+1:2].
- TAG_BITS, 30-INDEX_BITS, tag = cpu_address[31:INDEX_BITS+2]; derived, not overridden.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cpu_read  input  1  MEM-stage load request.
- cpu_write  input  1  MEM-stage store request.
- cpu_address  input  32  byte address; bits [1:0] ignored.
- cpu_write_data  input  32  store data.
- cpu_read_data  output  32  load data; valid when cpu_read=1 and cpu_stall=0.
- cpu_stall  output  1  freezes the pipeline; request must be held stable while 1.
- mem_write  output  1  to DataMemory mem_write.
- mem_address  output  32  to DataMemory address (registered).
- mem_write_data  output  32  to DataMemory write_data (registered).
- mem_read_data  input  32  from DataMemory read_data.
- mem_ready  input  1  from DataMemory mem_ready.
- hit_count  output  32  accepted read hits.
- miss_count  output  32  read misses.

Behaviour:
- Storage: per line, valid bit, TAG_BITS tag, 32-bit data. Combinational hit = valid[idx] & (tag[idx]==cpu tag).
- Reset (rst_n=0, asynchronous): all valid bits 0; state=IDLE; mem_write=0; mem_address=0; mem_write_data=0; hit_count=0; miss_count=0. Tag and data arrays are not reset.
- Reset mid-operation: the above applies immediately. The in-flight DataMemory access is abandoned and no line is filled.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, request priority: cpu_write wins if cpu_read and cpu_write are both 1; that case is treated as a write.
  - cpu_write: cpu_stall=1. Register mem_address=cpu_address, mem_write_data=cpu_write_data, mem_write=1. If hit, update the line data this edge; on a miss leave the cache unchanged (no allocate). Go to ISSUE.
  - cpu_read & hit: cpu_stall=0; cpu_read_data=line data, same cycle; hit_count+1. Stay in IDLE.
  - cpu_read & ~hit: cpu_stall=1; mem_address=cpu_address, mem_write=0; miss_count+1. Go to ISSUE.
  - no request: cpu_stall=0; cpu_read_data=data[idx] (don't-care).
- ISSUE: exactly one cycle, cpu_stall=1, mem_ready ignored. This covers a stale ready left over from the previous access. Go to WAIT.
- WAIT: cpu_stall=1; memory outputs held stable. Stay until mem_ready=1.
  - On ready for a read: valid[idx]=1, tag[idx]=cpu tag, data[idx]=mem_read_data.
  - On ready for a write: mem_write returns to 0 on this edge.
  - Go to DONE.
- DONE: one cycle, cpu_stall=0, so the request is consumed. For a read, cpu_read_data=data[idx], the newly filled line. No counter update, no new memory access. Go to IDLE.
- Stall timing: stall is asserted from the request cycle through the last WAIT cycle. If mem_ready rises D cycles after mem_address becomes stable, stall lasts D+1 cycles.
- Counters wrap modulo 2^32.
- Same-index conflict: a read miss overwrites the line unconditionally. No writeback is needed because the cache is write-through.
- Misaligned addresses: bits [1:0] are ignored for the cache. mem_address passes the full address through.

Test Plan:
- Reset, then cpu_read @64 with DataMemory #(3) preloaded 45 @64 -> stall 4 cycles, DONE returns 45; re-read @64 -> stall=0, data 45, hit_count=1, miss_count=1.
- cpu_write 100 @128 (miss) -> mem_write=1 with address 128 until mem_ready, then 0; line 0 stays invalid; later read @128 misses and returns 100.
- Read @64 (fill), then write 77 @64 -> line updated and memory written; read @64 hits with 77 and no stall.
- Conflict: read @64, then read @192 (same index 16, tag differs) -> second read misses and evicts; read @64 misses again; miss_count=3.
- cpu_read=1 and cpu_write=1 together @256, data 5 -> treated as a write; memory @256 becomes 5; miss_count unchanged.
- Assert rst_n=0 during WAIT of a read miss @64 -> mem_write=0, counters 0, state IDLE; after release, read @64 misses again.
